// File: rtl/proc_pkg.sv
// Shared definitions for the proc_flags multicycle processor: opcodes,
// instruction field positions, bus select codes, branch conditions,
// time-step encodings and the ALU operation type.
package proc_pkg;

   // Opcodes, IR[15:13]
   localparam logic [2:0] OP_MV    = 3'b000;
   localparam logic [2:0] OP_MVT_B = 3'b001;  // mvt when M=1, b{cond} when M=0
   localparam logic [2:0] OP_ADD   = 3'b010;
   localparam logic [2:0] OP_SUB   = 3'b011;
   localparam logic [2:0] OP_LD    = 3'b100;
   localparam logic [2:0] OP_ST    = 3'b101;
   localparam logic [2:0] OP_AND   = 3'b110;
   localparam logic [2:0] OP_CMP   = 3'b111;

   // Immediate/register operand select bit in IR
   localparam int M_BIT = 12;

   // Bus select codes; 0..6 are r0..r6, 7 is pc
   localparam logic [3:0] SEL_PC   = 4'd7;
   localparam logic [3:0] SEL_G    = 4'd8;
   localparam logic [3:0] SEL_DIN  = 4'd9;
   localparam logic [3:0] SEL_IMM  = 4'd10;
   localparam logic [3:0] SEL_MVT  = 4'd11;
   localparam logic [3:0] SEL_ZERO = 4'd15;

   // Branch condition codes, IR[11:9]
   localparam logic [2:0] COND_AL = 3'b000;
   localparam logic [2:0] COND_EQ = 3'b001;
   localparam logic [2:0] COND_NE = 3'b010;
   localparam logic [2:0] COND_CC = 3'b011;
   localparam logic [2:0] COND_CS = 3'b100;
   localparam logic [2:0] COND_PL = 3'b101;
   localparam logic [2:0] COND_MI = 3'b110;
   localparam logic [2:0] COND_NV = 3'b111;

   typedef enum logic [2:0] {
      T0 = 3'd0,
      T1 = 3'd1,
      T2 = 3'd2,
      T3 = 3'd3,
      T4 = 3'd4,
      T5 = 3'd5
   } tstep_t;

   typedef enum logic [1:0] {
      ALU_ADD = 2'd0,
      ALU_SUB = 2'd1,
      ALU_AND = 2'd2
   } alu_op_t;

   // Evaluate a branch condition against the current flags
   function automatic logic cond_met(input logic [2:0] cond, input logic z,
                                     input logic n, input logic c);
      logic w_met;
      case (cond)
         COND_AL: w_met = 1'b1;
         COND_EQ: w_met = z;
         COND_NE: w_met = ~z;
         COND_CC: w_met = ~c;
         COND_CS: w_met = c;
         COND_PL: w_met = ~n;
         COND_MI: w_met = n;
         default: w_met = 1'b0;
      endcase
      return w_met;
   endfunction

endpackage

// File: rtl/proc_alu.sv
// Datapath ALU: add, subtract (A + ~B + 1) and bitwise and, with carry out.
// For subtract the carry is 1 when no borrow occurs; for and it is 0 and
// the caller leaves its C flag untouched.
module proc_alu
   import proc_pkg::*;
#(
   parameter int DATA_W = 16
) (
   input  logic [DATA_W-1:0] i_a,
   input  logic [DATA_W-1:0] i_b,
   input  alu_op_t           i_op,
   output logic [DATA_W-1:0] o_result,
   output logic              o_c
);

   logic [DATA_W:0] w_sum;

   // Select the operation; results wrap modulo 2^DATA_W
   always_comb begin
      w_sum    = '0;
      o_result = '0;
      o_c      = 1'b0;
      case (i_op)
         ALU_ADD: begin
            w_sum    = {1'b0, i_a} + {1'b0, i_b};
            o_result = w_sum[DATA_W-1:0];
            o_c      = w_sum[DATA_W];
         end
         ALU_SUB: begin
            w_sum    = {1'b0, i_a} + {1'b0, ~i_b} + {{DATA_W{1'b0}}, 1'b1};
            o_result = w_sum[DATA_W-1:0];
            o_c      = w_sum[DATA_W];
         end
         ALU_AND: o_result = i_a & i_b;
         default: o_result = '0;
      endcase
   end

endmodule

// File: rtl/proc_flags.sv
// Multicycle processor with r0..r6, pc as r7, a shared bus, an A/G ALU path
// and Z/N/C condition flags used by conditional PC-relative branches.
// Run is sampled only in T0; Done is a one-cycle pulse in the last step of
// every instruction, with no backpressure. The FSM step is r_tstep.
module proc_flags
   import proc_pkg::*;
#(
   parameter int                DATA_W   = 16,
   parameter int                ADDR_W   = 16,
   parameter logic [DATA_W-1:0] RESET_PC = '0
) (
   input  logic              Clock,
   input  logic              Resetn,
   input  logic [DATA_W-1:0] DIN,
   input  logic              Run,
   output logic [DATA_W-1:0] DOUT,
   output logic [ADDR_W-1:0] ADDR,
   output logic              W,
   output logic              Done
);

   tstep_t            r_tstep, w_next;
   logic [DATA_W-1:0] r_reg [0:6];
   logic [DATA_W-1:0] r_pc, r_a, r_g, r_dout;
   logic [15:0]       r_ir;
   logic [ADDR_W-1:0] r_addr;
   logic              r_w, r_z, r_n, r_c;

   logic [2:0]        w_op, w_rx, w_ry;
   logic              w_m, w_taken;
   logic [7:0]        w_rx_dec, w_rin;
   logic [3:0]        w_sel;
   logic [DATA_W-1:0] w_bus, w_imm, w_mvt, w_alu_res;
   logic              w_alu_c;
   alu_op_t           w_alu_op;
   logic              w_a_in, w_g_in, w_flag_in, w_ir_in, w_addr_in;
   logic              w_dout_in, w_w_d, w_pc_inc, w_done;

   assign w_op     = r_ir[15:13];
   assign w_m      = r_ir[M_BIT];
   assign w_rx     = r_ir[11:9];
   assign w_ry     = r_ir[2:0];
   assign w_imm    = {{(DATA_W-9){r_ir[8]}}, r_ir[8:0]};
   assign w_rx_dec = 8'b1 << w_rx;
   assign w_taken  = cond_met(w_rx, r_z, r_n, r_c);

   assign DOUT = r_dout;
   assign ADDR = r_addr;
   assign W    = r_w;
   assign Done = w_done;

   // mvt value: IR[7:0] in bus[15:8], every other bit zero
   always_comb begin
      w_mvt       = '0;
      w_mvt[15:8] = r_ir[7:0];
   end

   // Bus multiplexer; unused select codes drive zero
   always_comb begin
      w_bus = '0;
      case (w_sel)
         4'd0:     w_bus = r_reg[0];
         4'd1:     w_bus = r_reg[1];
         4'd2:     w_bus = r_reg[2];
         4'd3:     w_bus = r_reg[3];
         4'd4:     w_bus = r_reg[4];
         4'd5:     w_bus = r_reg[5];
         4'd6:     w_bus = r_reg[6];
         SEL_PC:   w_bus = r_pc;
         SEL_G:    w_bus = r_g;
         SEL_DIN:  w_bus = DIN;
         SEL_IMM:  w_bus = w_imm;
         SEL_MVT:  w_bus = w_mvt;
         default:  w_bus = '0;
      endcase
   end

   proc_alu #(.DATA_W(DATA_W)) u_alu (
      .i_a      (r_a),
      .i_b      (w_bus),
      .i_op     (w_alu_op),
      .o_result (w_alu_res),
      .o_c      (w_alu_c)
   );

   // Time-step register
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) r_tstep <= T0;
      else         r_tstep <= w_next;
   end

   // Next step and datapath controls for the current step and opcode
   always_comb begin
      w_next    = r_tstep;
      w_sel     = SEL_ZERO;
      w_rin     = 8'h00;
      w_alu_op  = ALU_ADD;
      w_a_in    = 1'b0;
      w_g_in    = 1'b0;
      w_flag_in = 1'b0;
      w_ir_in   = 1'b0;
      w_addr_in = 1'b0;
      w_dout_in = 1'b0;
      w_w_d     = 1'b0;
      w_pc_inc  = 1'b0;
      w_done    = 1'b0;
      case (r_tstep)
         T0: begin
            w_sel     = SEL_PC;
            w_addr_in = 1'b1;
            if (Run) begin
               w_pc_inc = 1'b1;
               w_next   = T1;
            end
         end
         T1: w_next = T2;
         T2: begin
            w_ir_in = 1'b1;
            w_next  = T3;
         end
         T3: begin
            case (w_op)
               OP_MV: begin
                  w_sel  = w_m ? SEL_IMM : {1'b0, w_ry};
                  w_rin  = w_rx_dec;
                  w_done = 1'b1;
                  w_next = T0;
               end
               OP_MVT_B: begin
                  if (w_m) begin
                     w_sel  = SEL_MVT;
                     w_rin  = w_rx_dec;
                     w_done = 1'b1;
                     w_next = T0;
                  end else if (w_taken) begin
                     w_sel  = SEL_PC;
                     w_a_in = 1'b1;
                     w_next = T4;
                  end else begin
                     w_done = 1'b1;
                     w_next = T0;
                  end
               end
               OP_ADD, OP_SUB, OP_AND, OP_CMP: begin
                  w_sel  = {1'b0, w_rx};
                  w_a_in = 1'b1;
                  w_next = T4;
               end
               default: begin  // ld, st
                  w_sel     = {1'b0, w_ry};
                  w_addr_in = 1'b1;
                  w_next    = T4;
               end
            endcase
         end
         T4: begin
            w_next = T5;
            case (w_op)
               OP_ADD, OP_SUB, OP_AND, OP_CMP: begin
                  w_sel     = w_m ? SEL_IMM : {1'b0, w_ry};
                  w_alu_op  = (w_op == OP_ADD) ? ALU_ADD :
                              (w_op == OP_AND) ? ALU_AND : ALU_SUB;
                  w_g_in    = 1'b1;
                  w_flag_in = 1'b1;
                  if (w_op == OP_CMP) begin
                     w_done = 1'b1;
                     w_next = T0;
                  end
               end
               OP_MVT_B: begin  // taken branch: G = pc + offset
                  w_sel  = SEL_IMM;
                  w_g_in = 1'b1;
               end
               OP_ST: begin
                  w_sel     = {1'b0, w_rx};
                  w_dout_in = 1'b1;
                  w_w_d     = 1'b1;
               end
               OP_LD: w_next = T5;
               default: w_next = T0;
            endcase
         end
         T5: begin
            w_done = 1'b1;
            w_next = T0;
            case (w_op)
               OP_ADD, OP_SUB, OP_AND: begin
                  w_sel = SEL_G;
                  w_rin = w_rx_dec;
               end
               OP_MVT_B: begin
                  w_sel = SEL_G;
                  w_rin = 8'h80;
               end
               OP_LD: begin
                  w_sel = SEL_DIN;
                  w_rin = w_rx_dec;
               end
               default: w_rin = 8'h00;
            endcase
         end
         default: w_next = T0;
      endcase
   end

   // Datapath registers and flags; a pc load outranks the fetch increment
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         for (int i = 0; i < 7; i++) r_reg[i] <= '0;
         r_pc   <= RESET_PC;
         r_a    <= '0;
         r_g    <= '0;
         r_ir   <= '0;
         r_dout <= '0;
         r_addr <= '0;
         r_w    <= 1'b0;
         r_z    <= 1'b0;
         r_n    <= 1'b0;
         r_c    <= 1'b0;
      end else begin
         for (int i = 0; i < 7; i++) begin
            if (w_rin[i]) r_reg[i] <= w_bus;
         end
         if (w_rin[7])      r_pc <= w_bus;
         else if (w_pc_inc) r_pc <= r_pc + DATA_W'(1);
         if (w_a_in)    r_a    <= w_bus;
         if (w_g_in)    r_g    <= w_alu_res;
         if (w_ir_in)   r_ir   <= DIN[15:0];
         if (w_addr_in) r_addr <= w_bus[ADDR_W-1:0];
         if (w_dout_in) r_dout <= w_bus;
         r_w <= w_w_d;
         if (w_flag_in) begin
            r_z <= (w_alu_res == '0);
            r_n <= w_alu_res[DATA_W-1];
            if (w_alu_op != ALU_AND) r_c <= w_alu_c;
         end
      end
   end

endmodule

// File: tb/tb_proc_flags.sv
// Bench for proc_flags: directed programs with hand-computed results.
// Expected per-instruction results go into exp_q and expected stores into
// st_q; a negedge monitor pops them on Done / W.
module tb_proc_flags;

   typedef struct {
      string       name;
      int          ridx;    // -1: no register check
      logic [31:0] val;
      bit          chk_f;
      logic [2:0]  flags;   // {Z,N,C}
      bit          chk_pc;
      logic [31:0] pc;
      int          len;     // cycles since previous Done / reset release
   } exp_t;

   logic        clk;
   logic        Resetn, Run;
   logic [15:0] DIN, DOUT, ADDR;
   logic        W, Done;

   logic        rst32_n, run32;
   logic [31:0] din32, dout32;
   logic [15:0] addr32;
   logic        w32, done32;

   logic [15:0] prog   [256];
   logic [15:0] mem    [256];
   logic [31:0] prog32 [256];
   logic [31:0] mem32  [256];

   exp_t        exp_q[$];
   logic [31:0] st_q[$];
   exp_t        mon_e;
   bit          mon_pend;
   int          mon_cyc;
   int          n_chk, n_pass;

   proc_flags #(.DATA_W(16), .ADDR_W(16), .RESET_PC(16'h0000)) dut (
      .Clock(clk), .Resetn(Resetn), .DIN(DIN), .Run(Run),
      .DOUT(DOUT), .ADDR(ADDR), .W(W), .Done(Done)
   );

   proc_flags #(.DATA_W(32), .ADDR_W(16), .RESET_PC(32'h0000_0000)) dut32 (
      .Clock(clk), .Resetn(rst32_n), .DIN(din32), .Run(run32),
      .DOUT(dout32), .ADDR(addr32), .W(w32), .Done(done32)
   );

   // Clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Synchronous memories, 1-cycle read latency, program image loaded in reset
   always @(posedge clk) begin
      if (!Resetn) begin
         for (int i = 0; i < 256; i++) mem[i] <= prog[i];
      end else if (W) begin
         mem[ADDR[7:0]] <= DOUT;
      end
      DIN <= mem[ADDR[7:0]];
   end

   always @(posedge clk) begin
      if (!rst32_n) begin
         for (int i = 0; i < 256; i++) mem32[i] <= prog32[i];
      end else if (w32) begin
         mem32[addr32[7:0]] <= dout32;
      end
      din32 <= mem32[addr32[7:0]];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   function automatic logic [31:0] get_reg(input int i);
      if (i == 7) return {16'h0000, dut.r_pc};
      return {16'h0000, dut.r_reg[i]};
   endfunction

   function automatic logic [15:0] enc(input logic [2:0] op, input logic m,
                                       input logic [2:0] rx, input logic [8:0] d);
      return {op, m, rx, d};
   endfunction

   task automatic push(input string name, input int ridx, input logic [31:0] val,
                       input bit chk_f, input logic [2:0] flags,
                       input bit chk_pc, input logic [31:0] pc, input int len);
      exp_t e;
      e.name = name; e.ridx = ridx; e.val = val; e.chk_f = chk_f;
      e.flags = flags; e.chk_pc = chk_pc; e.pc = pc; e.len = len;
      exp_q.push_back(e);
   endtask

   task automatic clear_prog();
      for (int i = 0; i < 256; i++) prog[i] = 16'h0000;
   endtask

   task automatic start_prog();
      Resetn = 1'b0;
      repeat (2) @(posedge clk);
      #2 Resetn = 1'b1;
   endtask

   task automatic wait_idle(input string name);
      int k;
      k = 0;
      while ((exp_q.size() != 0 || st_q.size() != 0) && k < 300) begin
         @(negedge clk);
         k++;
      end
      if (k >= 300) begin
         n_chk++;
         $display("FAIL %s timeout: %0d events pending, required 0", name,
                  exp_q.size() + st_q.size());
         exp_q.delete();
         st_q.delete();
      end
   endtask

   // Monitor: check register/flag/pc state the cycle after each Done,
   // instruction length at Done, and every W cycle against st_q
   always @(negedge clk) begin
      if (!Resetn) begin
         mon_cyc  = 0;
         mon_pend = 1'b0;
      end else begin
         if (mon_pend) begin
            mon_e = exp_q.pop_front();
            if (mon_e.ridx >= 0) chk({mon_e.name, "_reg"}, get_reg(mon_e.ridx), mon_e.val);
            if (mon_e.chk_f)  chk({mon_e.name, "_flags"}, {29'd0, dut.r_z, dut.r_n, dut.r_c},
                                  {29'd0, mon_e.flags});
            if (mon_e.chk_pc) chk({mon_e.name, "_pc"}, {16'h0000, dut.r_pc}, mon_e.pc);
            mon_pend = 1'b0;
         end
         mon_cyc++;
         if (W) begin
            if (st_q.size() == 0) begin
               n_chk++;
               $display("FAIL unexpected_W: W=1 with ADDR=%h DOUT=%h, required W=0", ADDR, DOUT);
            end else begin
               chk("store_addr_dout", {ADDR, DOUT}, st_q.pop_front());
            end
         end
         if (Done) begin
            if (exp_q.size() > 0) begin
               chk({exp_q[0].name, "_len"}, 32'(mon_cyc), 32'(exp_q[0].len));
               mon_pend = 1'b1;
            end
            mon_cyc = 0;
         end
      end
   end

   // Directed programs
   initial begin
      int nd;
      n_chk = 0; n_pass = 0;
      Resetn = 1'b0; Run = 1'b0; rst32_n = 1'b0; run32 = 1'b1;
      clear_prog();
      for (int i = 0; i < 256; i++) prog32[i] = 32'h0;
      @(negedge clk); @(negedge clk);

      // Reset state
      chk("rst_ADDR", {16'h0000, ADDR}, 32'h0);
      chk("rst_DOUT", {16'h0000, DOUT}, 32'h0);
      chk("rst_W_Done", {30'd0, W, Done}, 32'h0);
      chk("rst_pc", get_reg(7), 32'h0);
      chk("rst_ir", {16'h0000, dut.r_ir}, 32'h0);
      chk("rst_flags", {29'd0, dut.r_z, dut.r_n, dut.r_c}, 32'h0);
      for (int i = 0; i < 7; i++) chk($sformatf("rst_r%0d", i), get_reg(i), 32'h0);

      // Run low: stays in T0, pc unchanged
      @(posedge clk); #2 Resetn = 1'b1;
      repeat (4) @(negedge clk);
      chk("idle_pc", get_reg(7), 32'h0);
      chk("idle_state", 32'(dut.r_tstep), 32'h0);
      Run = 1'b1;

      // mv r0,#5; mvt r1,#0x12
      clear_prog();
      prog[0] = enc(3'b000, 1'b1, 3'd0, 9'h005);
      prog[1] = enc(3'b001, 1'b1, 3'd1, 9'h012);
      prog[2] = enc(3'b001, 1'b0, 3'd0, 9'h1FF);
      push("mv_r0", 0, 32'h0005, 0, 3'b000, 0, 0, 4);
      push("mvt_r1", 1, 32'h1200, 0, 3'b000, 1, 32'd2, 4);
      start_prog();
      wait_idle("prog_mv");

      // Flag-setting arithmetic
      clear_prog();
      prog[0] = enc(3'b000, 1'b1, 3'd0, 9'h1FF);
      prog[1] = enc(3'b010, 1'b1, 3'd0, 9'h001);
      prog[2] = enc(3'b011, 1'b1, 3'd0, 9'h001);
      prog[3] = enc(3'b010, 1'b1, 3'd0, 9'h002);
      prog[4] = enc(3'b110, 1'b1, 3'd0, 9'h1FF);
      prog[5] = enc(3'b001, 1'b0, 3'd0, 9'h1FF);
      push("mv_m1", 0, 32'hFFFF, 0, 3'b000, 0, 0, 4);
      push("add_wrap", 0, 32'h0000, 1, 3'b101, 0, 0, 6);
      push("sub_borrow", 0, 32'hFFFF, 1, 3'b010, 0, 0, 6);
      push("add_carry", 0, 32'h0001, 1, 3'b001, 0, 0, 6);
      push("and_keep_c", 0, 32'h0001, 1, 3'b001, 1, 32'd5, 6);
      start_prog();
      wait_idle("prog_alu");

      // cmp then beq taken
      clear_prog();
      prog[0] = enc(3'b000, 1'b1, 3'd2, 9'h003);
      prog[1] = enc(3'b111, 1'b1, 3'd2, 9'h003);
      prog[2] = enc(3'b001, 1'b0, 3'd1, 9'h002);
      prog[3] = enc(3'b000, 1'b1, 3'd6, 9'h001);
      prog[4] = enc(3'b000, 1'b1, 3'd6, 9'h002);
      prog[5] = enc(3'b000, 1'b1, 3'd6, 9'h007);
      prog[6] = enc(3'b001, 1'b0, 3'd0, 9'h1FF);
      push("mv_r2", 2, 32'h0003, 0, 3'b000, 0, 0, 4);
      push("cmp_eq", 2, 32'h0003, 1, 3'b101, 0, 0, 5);
      push("beq_taken", -1, 0, 0, 3'b000, 1, 32'd5, 6);
      push("after_beq", 6, 32'h0007, 0, 3'b000, 1, 32'd6, 4);
      start_prog();
      wait_idle("prog_beq");

      // cmp then bne not taken
      prog[2] = enc(3'b001, 1'b0, 3'd2, 9'h002);
      prog[4] = enc(3'b001, 1'b0, 3'd0, 9'h1FF);
      push("mv_r2b", 2, 32'h0003, 0, 3'b000, 0, 0, 4);
      push("cmp_eq_b", 2, 32'h0003, 1, 3'b101, 0, 0, 5);
      push("bne_not_taken", -1, 0, 0, 3'b000, 1, 32'd3, 4);
      push("after_bne", 6, 32'h0001, 0, 3'b000, 1, 32'd4, 4);
      start_prog();
      wait_idle("prog_bne");

      // Store then load
      clear_prog();
      prog[0] = enc(3'b000, 1'b1, 3'd3, 9'h040);
      prog[1] = enc(3'b000, 1'b1, 3'd4, 9'h055);
      prog[2] = enc(3'b101, 1'b0, 3'd4, 9'h003);
      prog[3] = enc(3'b100, 1'b0, 3'd5, 9'h003);
      prog[4] = enc(3'b001, 1'b0, 3'd0, 9'h1FF);
      push("mv_r3", 3, 32'h0040, 0, 3'b000, 0, 0, 4);
      push("mv_r4", 4, 32'h0055, 0, 3'b000, 0, 0, 4);
      push("st", -1, 0, 0, 3'b000, 1, 32'd3, 6);
      push("ld_r5", 5, 32'h0055, 0, 3'b000, 0, 0, 6);
      st_q.push_back({16'h0040, 16'h0055});
      start_prog();
      wait_idle("prog_ldst");

      // Reset during T4 of add r1,#5 (add fetched from address 1)
      clear_prog();
      prog[0] = enc(3'b000, 1'b1, 3'd2, 9'h007);
      prog[1] = enc(3'b010, 1'b1, 3'd1, 9'h005);
      prog[2] = enc(3'b001, 1'b0, 3'd0, 9'h1FF);
      push("pre_mv_r2", 2, 32'h0007, 0, 3'b000, 0, 0, 4);
      start_prog();
      repeat (8) @(negedge clk);
      chk("pre_rst_pc", get_reg(7), 32'd2);
      @(negedge clk);
      Resetn = 1'b0;
      #1;
      chk("midrst_ADDR", {16'h0000, ADDR}, 32'h0);
      chk("midrst_DOUT_W_Done", {DOUT, 14'd0, W, Done}, 32'h0);
      chk("midrst_pc", get_reg(7), 32'h0);
      chk("midrst_r1", get_reg(1), 32'h0);
      chk("midrst_r2", get_reg(2), 32'h0);
      exp_q.delete();
      push("re_mv_r2", 2, 32'h0007, 0, 3'b000, 0, 0, 4);
      push("re_add_r1", 1, 32'h0005, 1, 3'b000, 1, 32'd2, 6);
      start_prog();
      wait_idle("prog_midrst");

      // 32-bit build: mv r0,#-2; add r0,#1; ld r1,[r0]
      prog32[0]   = {16'h0, enc(3'b000, 1'b1, 3'd0, 9'h1FE)};
      prog32[1]   = {16'h0, enc(3'b010, 1'b1, 3'd0, 9'h001)};
      prog32[2]   = {16'h0, enc(3'b100, 1'b0, 3'd1, 9'h000)};
      prog32[3]   = {16'h0, enc(3'b001, 1'b0, 3'd0, 9'h1FF)};
      prog32[255] = 32'h0BAD_F00D;
      repeat (2) @(posedge clk);
      #2 rst32_n = 1'b1;
      nd = 0;
      for (int k = 0; k < 200 && nd < 3; k++) begin
         @(negedge clk);
         if (done32) nd++;
      end
      if (nd < 3) begin
         n_chk++;
         $display("FAIL w32_done_timeout: got %0d Done pulses, required 3", nd);
      end else begin
         @(negedge clk);
         chk("w32_r0", dut32.r_reg[0], 32'hFFFF_FFFF);
         chk("w32_nc", {30'd0, dut32.r_n, dut32.r_c}, 32'h2);
         chk("w32_addr", {16'h0000, addr32}, 32'h0000_FFFF);
         chk("w32_ld_r1", dut32.r_reg[1], 32'h0BAD_F00D);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
